i2c_slave: RTL and testbench

//  I2C target (responder) that answers a 7-bit address on an open-drain SDA/SCL bus.

---
 rtl/i2c_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: filtered SCL/SDA inputs, 7-bit address match, byte-wide write delivery and read
// byte requests toward the host logic. Open-drain SDA, SCL is never driven (no stretching).
module i2c_slave #(
  parameter int FILT_LEN = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [6:0] i_addr7,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_req,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rw,
  output logic       o_busy,
  output logic       o_start,
  output logic       o_stop,
  output logic [2:0] o_dbg_state,
  inout  wire        io_i2c_sda,
  inout  wire        io_i2c_scl
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_A_ACK, S_RX, S_R_ACK, S_TX, S_M_ACK, S_WAIT_STOP
  } state_t;

  logic          r_scl_meta, r_scl_sync, r_scl_f, r_scl_fd;
  logic          r_sda_meta, r_sda_sync, r_sda_f, r_sda_fd;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;

  // A filtered level only follows the synchronised pin after FILT_LEN consecutive differing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_meta <= 1'b1; r_scl_sync <= 1'b1; r_scl_f <= 1'b1; r_scl_fd <= 1'b1;
      r_sda_meta <= 1'b1; r_sda_sync <= 1'b1; r_sda_f <= 1'b1; r_sda_fd <= 1'b1;
      r_scl_cnt  <= '0;   r_sda_cnt  <= '0;
    end else begin
      r_scl_meta <= io_i2c_scl;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= io_i2c_sda;
      r_sda_sync <= r_sda_meta;
      if (r_scl_sync == r_scl_f) r_scl_cnt <= '0;
      else if (r_scl_cnt == CNT_MAX) begin
        r_scl_f   <= r_scl_sync;
        r_scl_cnt <= '0;
      end else r_scl_cnt <= r_scl_cnt + 1'b1;
      if (r_sda_sync == r_sda_f) r_sda_cnt <= '0;
      else if (r_sda_cnt == CNT_MAX) begin
        r_sda_f   <= r_sda_sync;
        r_sda_cnt <= '0;
      end else r_sda_cnt <= r_sda_cnt + 1'b1;
      r_scl_fd <= r_scl_f;
      r_sda_fd <= r_sda_f;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  assign w_start    = r_scl_f & r_sda_fd & ~r_sda_f;
  assign w_stop     = r_scl_f & ~r_sda_fd & r_sda_f;

  state_t     r_state, w_state_nx;
  logic [2:0] r_bit, w_bit_nx;
  logic       r_done, w_done_nx;
  logic [7:0] r_shift, w_shift_nx, w_byte;
  logic [7:0] r_tx_sh, w_tx_sh_nx;
  logic       r_oe, w_oe_nx;
  logic       r_rw, w_rw_nx, r_busy, w_busy_nx;
  logic [7:0] r_rx_data, w_rx_data_nx;
  logic       r_rx_valid, w_rx_valid_nx, r_tx_req, w_tx_req_nx;
  logic       r_start, w_start_nx, r_stop, w_stop_nx;

  // r_done marks "byte (or ACK) complete on the last rise; act on the coming fall".
  always_comb begin
    w_state_nx    = r_state;
    w_bit_nx      = r_bit;
    w_done_nx     = r_done;
    w_shift_nx    = r_shift;
    w_tx_sh_nx    = r_tx_sh;
    w_oe_nx       = r_oe;
    w_rw_nx       = r_rw;
    w_busy_nx     = r_busy;
    w_rx_data_nx  = r_rx_data;
    w_rx_valid_nx = 1'b0;
    w_tx_req_nx   = 1'b0;
    w_start_nx    = 1'b0;
    w_stop_nx     = 1'b0;
    w_byte        = {r_shift[6:0], r_sda_f};
    if (!i_en) begin
      w_state_nx = S_IDLE;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
      w_bit_nx   = 3'd7;
      w_done_nx  = 1'b0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
      w_start_nx = 1'b1;
    end else if (w_stop) begin
      w_state_nx = S_IDLE;
      w_done_nx  = 1'b0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
      w_stop_nx  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            if (r_bit == 3'd0) begin
              if (w_byte[7:1] == i_addr7) begin
                w_rw_nx   = w_byte[0];
                w_busy_nx = 1'b1;
                w_done_nx = 1'b1;
              end else w_state_nx = S_WAIT_STOP;
            end else w_bit_nx = r_bit - 3'd1;
          end else if (w_scl_fall && r_done) begin
            w_oe_nx    = 1'b1;
            w_done_nx  = 1'b0;
            w_state_nx = S_A_ACK;
          end
        end
        S_A_ACK: begin
          if (w_scl_fall) begin
            w_bit_nx = 3'd7;
            if (r_rw) begin
              w_tx_req_nx = 1'b1;
              w_tx_sh_nx  = i_tx_data;
              w_oe_nx     = ~i_tx_data[7];
              w_state_nx  = S_TX;
            end else begin
              w_oe_nx    = 1'b0;
              w_state_nx = S_RX;
            end
          end
        end
        S_RX: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte;
            if (r_bit == 3'd0) w_done_nx = 1'b1;
            else               w_bit_nx  = r_bit - 3'd1;
          end else if (w_scl_fall && r_done) begin
            w_rx_data_nx  = r_shift;
            w_rx_valid_nx = 1'b1;
            w_oe_nx       = 1'b1;
            w_done_nx     = 1'b0;
            w_state_nx    = S_R_ACK;
          end
        end
        S_R_ACK: begin
          if (w_scl_fall) begin
            w_oe_nx    = 1'b0;
            w_bit_nx   = 3'd7;
            w_state_nx = S_RX;
          end
        end
        S_TX: begin
          if (w_scl_fall) begin
            if (r_bit == 3'd0) begin
              w_oe_nx    = 1'b0;
              w_done_nx  = 1'b0;
              w_state_nx = S_M_ACK;
            end else begin
              w_tx_sh_nx = {r_tx_sh[6:0], 1'b0};
              w_oe_nx    = ~r_tx_sh[6];
              w_bit_nx   = r_bit - 3'd1;
            end
          end
        end
        S_M_ACK: begin
          if (w_scl_rise) begin
            if (!r_sda_f) w_done_nx  = 1'b1;
            else          w_state_nx = S_WAIT_STOP;
          end else if (w_scl_fall && r_done) begin
            w_done_nx   = 1'b0;
            w_tx_req_nx = 1'b1;
            w_tx_sh_nx  = i_tx_data;
            w_oe_nx     = ~i_tx_data[7];
            w_bit_nx    = 3'd7;
            w_state_nx  = S_TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bit      <= 3'd7;
      r_done     <= 1'b0;
      r_shift    <= 8'h00;
      r_tx_sh    <= 8'h00;
      r_oe       <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_bit      <= w_bit_nx;
      r_done     <= w_done_nx;
      r_shift    <= w_shift_nx;
      r_tx_sh    <= w_tx_sh_nx;
      r_oe       <= w_oe_nx;
      r_rw       <= w_rw_nx;
      r_busy     <= w_busy_nx;
      r_rx_data  <= w_rx_data_nx;
      r_rx_valid <= w_rx_valid_nx;
      r_tx_req   <= w_tx_req_nx;
      r_start    <= w_start_nx;
      r_stop     <= w_stop_nx;
    end
  end

  // i_en gates the driver directly so disabling releases the bus without waiting a clock.
  assign io_i2c_sda  = (r_oe && i_en) ? 1'b0 : 1'bz;
  assign o_tx_req    = r_tx_req;
  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_rw        = r_rw;
  assign o_busy      = r_busy;
  assign o_start     = r_start;
  assign o_stop      = r_stop;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master drives the bus, a transaction-level model predicts
// ACKs, delivered bytes and pulse counts.
module tb_i2c_slave;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [6:0] addr7 = 7'h50;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req, rx_valid, rw, busy, start_p, stop_p;
  logic [7:0] rx_data;
  logic [2:0] dbg_state;
  logic       m_sda_low = 1'b0;
  logic       m_scl_low = 1'b0;
  wire        sda_bus, scl_bus;

  pullup (sda_bus);
  pullup (scl_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;

  i2c_slave #(.FILT_LEN(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_addr7(addr7), .i_tx_data(tx_data),
    .o_tx_req(tx_req), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_rw(rw),
    .o_busy(busy), .o_start(start_p), .o_stop(stop_p), .o_dbg_state(dbg_state),
    .io_i2c_sda(sda_bus), .io_i2c_scl(scl_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txreq = 0, n_busy = 0, n_pull = 0, n_bad = 0;
  logic p_start = 1'b0, p_stop = 1'b0, p_rxv = 1'b0, p_txr = 1'b0;
  logic [7:0] got_rx[$];
  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];

  always @(negedge clk) begin
    if (start_p)  n_start <= n_start + 1;
    if (stop_p)   n_stop  <= n_stop + 1;
    if (rx_valid) n_rxv   <= n_rxv + 1;
    if (tx_req)   n_txreq <= n_txreq + 1;
    if (busy)     n_busy  <= n_busy + 1;
    if (sda_bus === 1'b0 && !m_sda_low) n_pull <= n_pull + 1;
    if (rx_valid) got_rx.push_back(rx_data);
    if ((start_p && p_start) || (stop_p && p_stop) || (rx_valid && p_rxv) ||
        (tx_req && p_txr) || (rx_valid && tx_req)) n_bad <= n_bad + 1;
    p_start <= start_p;
    p_stop  <= stop_p;
    p_rxv   <= rx_valid;
    p_txr   <= tx_req;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input bit b, input bit glitch, output bit s);
    m_sda_low = !b;
    if (glitch) begin
      wait_clks(3);
      m_scl_low = 1'b0;
      wait_clks(2);
      m_scl_low = 1'b1;
      wait_clks(Q - 5);
    end else wait_clks(Q);
    m_scl_low = 1'b0;
    wait_clks(Q);
    s = (sda_bus !== 1'b0);
    wait_clks(Q);
    m_scl_low = 1'b1;
    wait_clks(Q);
  endtask

  task automatic m_start();
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl_low = 1'b0;
    wait_clks(2 * Q);
    m_sda_low = 1'b1;
    wait_clks(2 * Q);
    m_scl_low = 1'b1;
    wait_clks(Q);
  endtask

  task automatic m_stop();
    m_sda_low = 1'b1;
    wait_clks(Q);
    m_scl_low = 1'b0;
    wait_clks(2 * Q);
    m_sda_low = 1'b0;
    wait_clks(2 * Q);
  endtask

  task automatic m_write_byte(input logic [7:0] b, input int gbit, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == gbit), s);
    clk_bit(1'b1, 1'b0, s);
    ack = !s;
  endtask

  task automatic m_read_byte(input logic [7:0] nxt, input bit nack, output logic [7:0] d);
    bit s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    tx_data = nxt;
    clk_bit(nack, 1'b0, s);
  endtask

  task automatic test_reset();
    int e0;
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    rst = 1'b1;
    wait_clks(3);
    checks++;
    if ({tx_req, rx_valid, rw, busy, start_p, stop_p, rx_data} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {tx_req, rx_valid, rw, busy, start_p, stop_p, rx_data});
    end
    checks++;
    if (sda_bus !== 1'b1) begin
      errors++;
      $display("FAIL reset_sda: got %b expected 1", sda_bus);
    end
    rst = 1'b0;
    e0 = n_start + n_stop + n_rxv + n_txreq + n_pull;
    wait_clks(100);
    checks++;
    if (n_start + n_stop + n_rxv + n_txreq + n_pull != e0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d events expected 0", n_start + n_stop + n_rxv + n_txreq + n_pull - e0);
    end
  endtask

  // Master writes stim_q to target; the model says the slave ACKs and delivers only if target == own.
  task automatic run_write(input logic [6:0] own, input logic [6:0] tgt, input int gbit);
    bit ack, match;
    int s0, p0, r0, t0, b0, l0, base, n;
    match = (own == tgt);
    n = stim_q.size();
    addr7 = own;
    s0 = n_start; p0 = n_stop; r0 = n_rxv; t0 = n_txreq; b0 = n_busy; l0 = n_pull;
    base = got_rx.size();
    m_start();
    m_write_byte({tgt, 1'b0}, -1, ack);
    checks++;
    if (ack !== match) begin
      errors++;
      $display("FAIL wr_addr_ack: got %0b expected %0b (addr %0h own %0h)", ack, match, tgt, own);
    end
    if (match) begin
      checks++;
      if ({rw, busy} !== 2'b01) begin
        errors++;
        $display("FAIL wr_rw_busy: got %b expected 01", {rw, busy});
      end
      for (int i = 0; i < n; i++) begin
        m_write_byte(stim_q[i], (i == 0) ? gbit : -1, ack);
        exp_q.push_back(stim_q[i]);
        checks++;
        if (ack !== 1'b1) begin
          errors++;
          $display("FAIL wr_data_ack: got %0b expected 1 (byte %0d)", ack, i);
        end
      end
    end
    m_stop();
    wait_clks(10);
    checks++;
    if ((n_start - s0) != 1 || (n_stop - p0) != 1) begin
      errors++;
      $display("FAIL wr_start_stop: got %0d/%0d expected 1/1", n_start - s0, n_stop - p0);
    end
    checks++;
    if ((n_rxv - r0) != exp_q.size() || (n_txreq - t0) != 0) begin
      errors++;
      $display("FAIL wr_pulses: got rxv %0d txreq %0d expected %0d/0", n_rxv - r0, n_txreq - t0, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_busy_end: got %b expected 0", busy);
    end
    if (!match) begin
      checks++;
      if ((n_pull - l0) != 0 || (n_busy - b0) != 0) begin
        errors++;
        $display("FAIL wr_foreign: got pull %0d busy %0d expected 0/0", n_pull - l0, n_busy - b0);
      end
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (got_rx.size() <= base + i) begin
        errors++;
        $display("FAIL wr_rx_data: got none expected %02h", e);
      end else if (got_rx[base + i] !== e) begin
        errors++;
        $display("FAIL wr_rx_data: got %02h expected %02h", got_rx[base + i], e);
      end
    end
    stim_q.delete();
  endtask

  // Master reads stim_q.size() bytes, NACKing the last; stim_q holds what the host supplies.
  task automatic run_read(input logic [6:0] own, input logic [6:0] tgt);
    bit ack, match;
    logic [7:0] d;
    int s0, p0, r0, t0, b0, l0, n;
    match = (own == tgt);
    n = stim_q.size();
    addr7 = own;
    tx_data = stim_q[0];
    s0 = n_start; p0 = n_stop; r0 = n_rxv; t0 = n_txreq; b0 = n_busy; l0 = n_pull;
    m_start();
    m_write_byte({tgt, 1'b1}, -1, ack);
    checks++;
    if (ack !== match) begin
      errors++;
      $display("FAIL rd_addr_ack: got %0b expected %0b (addr %0h own %0h)", ack, match, tgt, own);
    end
    if (match) begin
      checks++;
      if ({rw, busy} !== 2'b11) begin
        errors++;
        $display("FAIL rd_rw_busy: got %b expected 11", {rw, busy});
      end
      for (int i = 0; i < n; i++) begin
        m_read_byte((i + 1 < n) ? stim_q[i + 1] : 8'h00, (i == n - 1), d);
        checks++;
        if (d !== stim_q[i]) begin
          errors++;
          $display("FAIL rd_data: got %02h expected %02h (byte %0d)", d, stim_q[i], i);
        end
      end
      checks++;
      if (sda_bus !== 1'b1) begin
        errors++;
        $display("FAIL rd_release: got %b expected 1", sda_bus);
      end
    end
    m_stop();
    wait_clks(10);
    checks++;
    if ((n_txreq - t0) != (match ? n : 0) || (n_rxv - r0) != 0) begin
      errors++;
      $display("FAIL rd_pulses: got txreq %0d rxv %0d expected %0d/0", n_txreq - t0, n_rxv - r0, match ? n : 0);
    end
    checks++;
    if ((n_start - s0) != 1 || (n_stop - p0) != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_framing: got start %0d stop %0d busy %b expected 1/1/0", n_start - s0, n_stop - p0, busy);
    end
    if (!match) begin
      checks++;
      if ((n_pull - l0) != 0 || (n_busy - b0) != 0) begin
        errors++;
        $display("FAIL rd_foreign: got pull %0d busy %0d expected 0/0", n_pull - l0, n_busy - b0);
      end
    end
    stim_q.delete();
  endtask

  task automatic test_restart();
    bit ack;
    logic [7:0] d;
    int s0, r0, t0, base;
    addr7 = 7'h50;
    tx_data = 8'h5A;
    s0 = n_start; r0 = n_rxv; t0 = n_txreq; base = got_rx.size();
    m_start();
    m_write_byte(8'hA0, -1, ack);
    checks++;
    if (ack !== 1'b1 || rw !== 1'b0) begin
      errors++;
      $display("FAIL rs_first: got ack %0b rw %b expected 1/0", ack, rw);
    end
    m_write_byte(8'h07, -1, ack);
    m_start();
    m_write_byte(8'hA1, -1, ack);
    checks++;
    if (ack !== 1'b1 || rw !== 1'b1) begin
      errors++;
      $display("FAIL rs_second: got ack %0b rw %b expected 1/1", ack, rw);
    end
    m_read_byte(8'h00, 1'b1, d);
    m_stop();
    wait_clks(10);
    checks++;
    if ((n_start - s0) != 2 || (n_rxv - r0) != 1 || (n_txreq - t0) != 1) begin
      errors++;
      $display("FAIL rs_counts: got start %0d rxv %0d txreq %0d expected 2/1/1", n_start - s0, n_rxv - r0, n_txreq - t0);
    end
    checks++;
    if (got_rx.size() <= base || got_rx[base] !== 8'h07 || d !== 8'h5A) begin
      errors++;
      $display("FAIL rs_data: got rx %02h rd %02h expected 07/5a",
               (got_rx.size() > base) ? got_rx[base] : 8'hxx, d);
    end
  endtask

  task automatic test_zero_len();
    bit ack;
    int s0, p0, r0, t0, b0;
    addr7 = 7'h50;
    s0 = n_start; p0 = n_stop; r0 = n_rxv; t0 = n_txreq; b0 = n_busy;
    m_start();
    m_write_byte(8'hA0, -1, ack);
    m_stop();
    wait_clks(10);
    checks++;
    if ((n_start - s0) != 1 || (n_stop - p0) != 1 || (n_busy - b0) == 0 || (n_rxv - r0) != 0 || (n_txreq - t0) != 0) begin
      errors++;
      $display("FAIL zero_len: got start %0d stop %0d busy %0d rxv %0d txreq %0d expected 1/1/>0/0/0",
               n_start - s0, n_stop - p0, n_busy - b0, n_rxv - r0, n_txreq - t0);
    end
  endtask

  task automatic test_en_drop();
    bit s;
    int p0, r0;
    logic [7:0] a;
    a = 8'hA0;
    addr7 = 7'h50;
    p0 = n_stop; r0 = n_rxv;
    m_start();
    for (int i = 7; i >= 0; i--) clk_bit(a[i], 1'b0, s);
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl_low = 1'b0;
    wait_clks(Q);
    checks++;
    if (sda_bus !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL en_pre: got sda %b busy %b expected 0/1", sda_bus, busy);
    end
    en = 1'b0;
    wait_clks(2);
    checks++;
    if (sda_bus !== 1'b1 || busy !== 1'b0 || (n_stop - p0) != 0 || (n_rxv - r0) != 0) begin
      errors++;
      $display("FAIL en_drop: got sda %b busy %b stop %0d rxv %0d expected 1/0/0/0", sda_bus, busy, n_stop - p0, n_rxv - r0);
    end
    m_scl_low = 1'b1;
    wait_clks(Q);
    en = 1'b1;
    wait_clks(Q);
    m_stop();
    wait_clks(10);
  endtask

  task automatic test_async_reset();
    bit ack;
    addr7 = 7'h50;
    tx_data = 8'h00;
    m_start();
    m_write_byte(8'hA1, -1, ack);
    m_sda_low = 1'b0;
    wait_clks(Q);
    m_scl_low = 1'b0;
    wait_clks(Q);
    checks++;
    if (sda_bus !== 1'b0) begin
      errors++;
      $display("FAIL ar_driving: got %b expected 0", sda_bus);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sda_bus !== 1'b1 || busy !== 1'b0 || rw !== 1'b0) begin
      errors++;
      $display("FAIL ar_release: got sda %b busy %b rw %b expected 1/0/0", sda_bus, busy, rw);
    end
    wait_clks(5);
    rst = 1'b0;
    wait_clks(20);
  endtask

  initial begin
    logic [6:0] own, tgt;
    int nb;
    test_reset();
    stim_q = '{8'hA5, 8'h3C};
    run_write(7'h50, 7'h50, -1);
    stim_q = '{8'h99};
    run_write(7'h50, 7'h28, -1);
    stim_q = '{8'h11, 8'h22, 8'h33};
    run_read(7'h50, 7'h50);
    stim_q = '{8'h44};
    run_read(7'h50, 7'h28);
    test_restart();
    test_zero_len();
    stim_q.push_back(8'($urandom_range(0, 255)));
    stim_q.push_back(8'($urandom_range(0, 255)));
    run_write(7'h50, 7'h50, 4);
    for (int k = 0; k < 6; k++) begin
      own = 7'($urandom_range(8, 119));
      tgt = ($urandom_range(0, 3) != 0) ? own : (own ^ 7'($urandom_range(1, 127)));
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) stim_q.push_back(8'($urandom_range(0, 255)));
      if (k % 2 == 1) run_read(own, tgt);
      else run_write(own, tgt, -1);
    end
    test_en_drop();
    test_async_reset();
    checks++;
    if (n_bad != 0) begin
      errors++;
      $display("FAIL pulse_shape: got %0d stretched/overlapping pulses expected 0", n_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
